// File: rtl/param_up_down_counter.sv
// param_up_down_counter: parameterised up/down/load counter.
// It supports configurable range bounds and step size, and it can either wrap
// or clamp at the bounds. It has combinational at_max/at_min flags and
// registered one-cycle crossing pulses (wrap_up/wrap_dn).
// Optional macro UDC_PRESCALE_EN: adds a prescaler so the count steps once
// every PRESCALE enabled up/down cycles.
module param_up_down_counter #(
  parameter int     WIDTH    = 4,
  parameter longint MIN_VAL  = 0,
  parameter longint MAX_VAL  = (64'd1 << WIDTH) - 1,
  parameter longint STEP     = 1,
  parameter bit     SATURATE = 1'b0,
  parameter int     PRESCALE = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [1:0]       up_dwn,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             at_max,
  output logic             at_min,
  output logic             wrap_up,
  output logic             wrap_dn
);

  typedef enum logic [1:0] {M_HOLD = 2'd0, M_UP = 2'd1, M_DN = 2'd2, M_LOAD = 2'd3} mode_e;

  // All bound arithmetic is one bit wider than the count, so MAX_VAL = 2**WIDTH-1
  // and a range of 2**WIDTH are both representable without truncation.
  localparam logic [WIDTH:0] L_MIN      = MIN_VAL[WIDTH:0];
  localparam logic [WIDTH:0] L_MAX      = MAX_VAL[WIDTH:0];
  localparam logic [WIDTH:0] L_STEP     = STEP[WIDTH:0];
  localparam longint         RANGE_L    = MAX_VAL - MIN_VAL + 1;
  localparam logic [WIDTH:0] L_RANGE    = RANGE_L[WIDTH:0];
  localparam logic [WIDTH:0] L_DN_FLOOR = L_MIN + L_STEP;  // smallest count that can step down cleanly

  mode_e            w_mode;
  logic             w_adv;    // enabled up/down request this cycle
  logic             w_tick;   // prescaler allows the step this cycle
  logic             w_step;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_cnt_ext;
  logic [WIDTH:0]   w_ld_ext;
  logic [WIDTH-1:0] w_nxt_count;
  logic             w_nxt_wu;
  logic             w_nxt_wd;
  logic [WIDTH-1:0] r_count;
  logic             r_wrap_up;
  logic             r_wrap_dn;

  assign w_mode    = mode_e'(up_dwn);
  assign w_adv     = en && ((w_mode == M_UP) || (w_mode == M_DN));
  assign w_step    = w_adv && w_tick;
  assign w_cnt_ext = {1'b0, r_count};
  assign w_ld_ext  = {1'b0, load_val};
  assign w_sum     = w_cnt_ext + L_STEP;

`ifdef UDC_PRESCALE_EN
  localparam int             PS_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

  logic [PS_W-1:0] r_ps;

  // Prescaler phase: advances on enabled up/down cycles and restarts on anything else.
  always_ff @(posedge clk) begin
    if (reset)            r_ps <= '0;
    else if (!w_adv)      r_ps <= '0;
    else if (r_ps == PS_LAST) r_ps <= '0;
    else                  r_ps <= r_ps + 1'b1;
  end

  assign w_tick = (r_ps == PS_LAST);
`else
  assign w_tick = 1'b1;
`endif

  // Next count and crossing pulses for the selected mode.
  always_comb begin
    w_nxt_count = r_count;
    w_nxt_wu    = 1'b0;
    w_nxt_wd    = 1'b0;
    unique case (w_mode)
      M_UP: if (w_step) begin
        if (w_sum <= L_MAX) begin
          w_nxt_count = WIDTH'(w_sum);
        end else begin
          w_nxt_wu    = 1'b1;
          w_nxt_count = SATURATE ? WIDTH'(L_MAX) : WIDTH'(w_sum - L_RANGE);
        end
      end
      M_DN: if (w_step) begin
        if (w_cnt_ext >= L_DN_FLOOR) begin
          w_nxt_count = WIDTH'(w_cnt_ext - L_STEP);
        end else begin
          w_nxt_wd    = 1'b1;
          w_nxt_count = SATURATE ? WIDTH'(L_MIN) : WIDTH'(w_cnt_ext + L_RANGE - L_STEP);
        end
      end
      M_LOAD: begin
        if (w_ld_ext < L_MIN)      w_nxt_count = WIDTH'(L_MIN);
        else if (w_ld_ext > L_MAX) w_nxt_count = WIDTH'(L_MAX);
        else                       w_nxt_count = load_val;
      end
      default: ;
    endcase
  end

  // Count and pulse registers; reset dominates every other input.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_count   <= WIDTH'(L_MIN);
      r_wrap_up <= 1'b0;
      r_wrap_dn <= 1'b0;
    end else begin
      r_count   <= w_nxt_count;
      r_wrap_up <= w_nxt_wu;
      r_wrap_dn <= w_nxt_wd;
    end
  end

  assign count   = r_count;
  assign at_max  = (w_cnt_ext == L_MAX);
  assign at_min  = (w_cnt_ext == L_MIN);
  assign wrap_up = r_wrap_up;
  assign wrap_dn = r_wrap_dn;

endmodule

// File: tb/tb_param_up_down_counter.sv
// Directed bench for param_up_down_counter. It runs three instances in
// parallel on shared inputs: the defaults (wrap), a saturating instance, and
// a 3..12 range with a step of 4. With UDC_PRESCALE_EN it runs the prescaler
// sequence instead.
module tb_param_up_down_counter;

  logic       clk, reset, en;
  logic [1:0] up_dwn;
  logic [3:0] load_val;

  logic [3:0] a_cnt, s_cnt, r_cnt;
  logic a_max, a_min, a_wu, a_wd;
  logic s_max, s_min, s_wu, s_wd;
  logic r_max, r_min, r_wu, r_wd;

  int nvec = 0;
  int nerr = 0;

  param_up_down_counter u_a (
    .clk(clk), .reset(reset), .en(en), .up_dwn(up_dwn), .load_val(load_val),
    .count(a_cnt), .at_max(a_max), .at_min(a_min), .wrap_up(a_wu), .wrap_dn(a_wd));

  param_up_down_counter #(.SATURATE(1'b1)) u_s (
    .clk(clk), .reset(reset), .en(en), .up_dwn(up_dwn), .load_val(load_val),
    .count(s_cnt), .at_max(s_max), .at_min(s_min), .wrap_up(s_wu), .wrap_dn(s_wd));

  param_up_down_counter #(.MIN_VAL(3), .MAX_VAL(12), .STEP(4)) u_r (
    .clk(clk), .reset(reset), .en(en), .up_dwn(up_dwn), .load_val(load_val),
    .count(r_cnt), .at_max(r_max), .at_min(r_min), .wrap_up(r_wu), .wrap_dn(r_wd));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       en;
    logic [1:0] md;
    logic [3:0] ld;
    logic [3:0] ca;  logic [1:0] wa;   // {wrap_up, wrap_dn}
    logic [3:0] cs;  logic [1:0] ws;
    logic [3:0] cr;  logic [1:0] wr;
  } vec_t;

  function automatic vec_t mk(input logic rst_i, input logic en_i, input logic [1:0] md_i,
                              input logic [3:0] ld_i,
                              input logic [3:0] ca_i, input logic [1:0] wa_i,
                              input logic [3:0] cs_i, input logic [1:0] ws_i,
                              input logic [3:0] cr_i, input logic [1:0] wr_i);
    vec_t v;
    v.rst = rst_i; v.en = en_i; v.md = md_i; v.ld = ld_i;
    v.ca = ca_i; v.wa = wa_i; v.cs = cs_i; v.ws = ws_i; v.cr = cr_i; v.wr = wr_i;
    return v;
  endfunction

  task automatic drive(input logic rst_i, input logic en_i, input logic [1:0] md_i,
                       input logic [3:0] ld_i);
    reset = rst_i; en = en_i; up_dwn = md_i; load_val = ld_i;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

`ifndef UDC_PRESCALE_EN
  vec_t tbl[29];
`endif

  initial begin
    reset = 1'b1; en = 1'b0; up_dwn = 2'd0; load_val = 4'd0;
    #1;
`ifndef UDC_PRESCALE_EN
    //               rst en md ld    ca  wa   cs  ws   cr  wr
    tbl[0]  = mk(1, 0, 0, 0,     0, 0,   0, 0,    3, 0);
    tbl[1]  = mk(1, 0, 0, 0,     0, 0,   0, 0,    3, 0);
    tbl[2]  = mk(0, 1, 1, 0,     1, 0,   1, 0,    7, 0);
    tbl[3]  = mk(0, 1, 1, 0,     2, 0,   2, 0,   11, 0);
    tbl[4]  = mk(0, 1, 1, 0,     3, 0,   3, 0,    5, 2);
    tbl[5]  = mk(0, 1, 3, 15,   15, 0,  15, 0,   12, 0);
    tbl[6]  = mk(0, 1, 1, 0,     0, 2,  15, 2,    6, 2);
    tbl[7]  = mk(0, 1, 0, 0,     0, 0,  15, 0,    6, 0);
    tbl[8]  = mk(0, 1, 3, 0,     0, 0,   0, 0,    3, 0);
    tbl[9]  = mk(0, 1, 2, 0,    15, 1,   0, 1,    9, 1);
    tbl[10] = mk(0, 1, 0, 0,    15, 0,   0, 0,    9, 0);
    tbl[11] = mk(0, 1, 3, 11,   11, 0,  11, 0,   11, 0);
    tbl[12] = mk(0, 1, 1, 0,    12, 0,  12, 0,    5, 2);
    tbl[13] = mk(0, 1, 3, 1,     1, 0,   1, 0,    3, 0);
    tbl[14] = mk(0, 1, 3, 14,   14, 0,  14, 0,   12, 0);
    tbl[15] = mk(0, 1, 3, 7,     7, 0,   7, 0,    7, 0);
    tbl[16] = mk(0, 0, 1, 0,     7, 0,   7, 0,    7, 0);
    tbl[17] = mk(0, 0, 1, 0,     7, 0,   7, 0,    7, 0);
    tbl[18] = mk(0, 0, 1, 0,     7, 0,   7, 0,    7, 0);
    tbl[19] = mk(0, 0, 2, 0,     7, 0,   7, 0,    7, 0);
    tbl[20] = mk(0, 1, 0, 0,     7, 0,   7, 0,    7, 0);
    tbl[21] = mk(1, 1, 1, 0,     0, 0,   0, 0,    3, 0);
    tbl[22] = mk(0, 1, 2, 0,    15, 1,   0, 1,    9, 1);
    tbl[23] = mk(0, 1, 2, 0,    14, 0,   0, 1,    5, 0);
    tbl[24] = mk(0, 1, 2, 0,    13, 0,   0, 1,   11, 1);
    tbl[25] = mk(0, 0, 3, 12,   12, 0,  12, 0,   12, 0);
    tbl[26] = mk(0, 1, 1, 0,    13, 0,  13, 0,    6, 2);
    tbl[27] = mk(0, 1, 3, 15,   15, 0,  15, 0,   12, 0);
    tbl[28] = mk(0, 1, 1, 0,     0, 2,  15, 2,    6, 2);

    for (int i = 0; i < 29; i++) begin
      logic [31:0] act, exp;
      drive(tbl[i].rst, tbl[i].en, tbl[i].md, tbl[i].ld);
      act = {a_cnt, a_wu, a_wd, a_max, a_min, s_cnt, s_wu, s_wd, s_max, s_min,
             r_cnt, r_wu, r_wd, r_max, r_min};
      exp = {tbl[i].ca, tbl[i].wa, tbl[i].ca == 4'd15, tbl[i].ca == 4'd0,
             tbl[i].cs, tbl[i].ws, tbl[i].cs == 4'd15, tbl[i].cs == 4'd0,
             tbl[i].cr, tbl[i].wr, tbl[i].cr == 4'd12, tbl[i].cr == 4'd3};
      chk($sformatf("vec%0d", i), act, exp);
    end

    // Long up run from 0: the wrapping counter pulses once, the saturating one pulses
    // on each attempt past its maximum, and no instance ever shows both pulses.
    begin
      int a_pulses = 0, s_pulses = 0, both = 0;
      drive(1'b0, 1'b1, 2'd3, 4'd0);
      for (int k = 0; k < 17; k++) begin
        drive(1'b0, 1'b1, 2'd1, 4'd0);
        if (a_wu) a_pulses++;
        if (s_wu) s_pulses++;
        if ((a_wu && a_wd) || (s_wu && s_wd) || (r_wu && r_wd) || a_wd || s_wd || r_wd) both++;
      end
      chk("run_a_count", 32'(a_cnt), 32'd1);
      chk("run_a_pulses", 32'(a_pulses), 32'd1);
      chk("run_s_count", 32'(s_cnt), 32'd15);
      chk("run_s_pulses", 32'(s_pulses), 32'd2);
      chk("run_no_dn_or_both", 32'(both), 32'd0);
    end
`else
    // Prescaler: the count advances on every 4th enabled up cycle.
    drive(1'b1, 1'b0, 2'd0, 4'd0);
    drive(1'b1, 1'b0, 2'd0, 4'd0);
    chk("ps_reset", 32'(a_cnt), 32'd0);
    for (int k = 1; k <= 12; k++) begin
      drive(1'b0, 1'b1, 2'd1, 4'd0);
      chk($sformatf("ps_up%0d", k), {a_cnt, a_wu, a_wd}, {4'(k / 4), 2'b00});
    end
    drive(1'b0, 1'b1, 2'd1, 4'd0);
    drive(1'b0, 1'b1, 2'd1, 4'd0);
    chk("ps_pre_load", 32'(a_cnt), 32'd3);
    drive(1'b0, 1'b1, 2'd3, 4'd5);
    chk("ps_load", 32'(a_cnt), 32'd5);
    for (int k = 1; k <= 4; k++) begin
      drive(1'b0, 1'b1, 2'd1, 4'd0);
      chk($sformatf("ps_after_load%0d", k), 32'(a_cnt), (k == 4) ? 32'd6 : 32'd5);
    end
`endif
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
